// File: rtl/wrr_pkg.sv
// ============================================================================
// Module : wrr_pkg
// Brief  : Shared FSM state encoding and sizing/slicing helpers for the
//          weighted round-robin credit arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wrr_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    // Index width with a floor of 1 so a single-bit id port is always legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int bid_lsb(input int ch, input int bid_w);
        return ch * bid_w;
    endfunction

    function automatic int bal_lsb(input int ch, input int bal_w);
        return ch * bal_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wrr_credit_ctr.sv
// ============================================================================
// Module : wrr_credit_ctr
// Brief  : One channel's credit balance: reload, debit, saturating refund.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wrr_credit_ctr #(
    parameter int BAL_W       = 10,
    parameter int AMT_W       = 4,
    parameter int CREDIT_INIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_init,
    input  logic             debit,
    input  logic [AMT_W-1:0] debit_amt,
    input  logic             refund,
    input  logic [AMT_W-1:0] refund_amt,
    output logic [BAL_W-1:0] balance
);

    localparam logic [BAL_W-1:0] C_INIT = BAL_W'(CREDIT_INIT);

    logic [BAL_W:0] w_sum;

    assign w_sum = {1'b0, balance} + (BAL_W+1)'(refund_amt);

    always_ff @(posedge clk) begin
        if (rst || load_init) begin
            balance <= C_INIT;
        end else if (debit) begin
            balance <= balance - BAL_W'(debit_amt);
        end else if (refund) begin
            balance <= (w_sum > {1'b0, C_INIT}) ? C_INIT : w_sum[BAL_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wrr_credit_arbiter.sv
// ============================================================================
// Module : wrr_credit_arbiter
// Brief  : Weighted round-robin arbiter, highest affordable bid wins, with
//          per-channel credit balances and epoch refill.
//          Optional macro WRR_EARLY_RELEASE_EN: end a burst early when the
//          granted request drops and refund the unused cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wrr_credit_arbiter
    import wrr_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int BID_W       = 4,
    parameter int BAL_W       = 10,
    parameter int CREDIT_INIT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*BID_W-1:0]    bid,
    output logic [N_CH-1:0]          grant,
    output logic [clog2(N_CH)-1:0]   grant_id,
    output logic                     busy,
    output logic                     refill,
    output logic [N_CH*BAL_W-1:0]    balance
);

    localparam int               IDX_W  = clog2(N_CH);
    localparam logic [IDX_W:0]   C_NCH  = (IDX_W+1)'(N_CH);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_CH - 1);

    state_t            r_state;
    logic [N_CH-1:0]   r_grant;
    logic [IDX_W-1:0]  r_grant_id;
    logic              r_busy;
    logic              r_refill;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [BID_W-1:0]  r_cnt;

    logic [BID_W-1:0]  w_bid [N_CH];
    logic [BAL_W-1:0]  w_bal [N_CH];
    logic [N_CH-1:0]   w_elig;
    logic [N_CH-1:0]   w_pending;
    logic [N_CH-1:0]   w_debit;
    logic [N_CH-1:0]   w_refund;
    logic              w_any_elig;
    logic [IDX_W-1:0]  w_win;
    logic [BID_W-1:0]  w_win_bid;
    logic [IDX_W:0]    w_sum;
    logic [IDX_W-1:0]  w_idx;
    logic              w_load;
    logic              w_release;
    logic [BID_W-1:0]  w_refund_amt;

    assign w_load = (r_state == S_REFILL);

`ifdef WRR_EARLY_RELEASE_EN
    // The final burst cycle ends the grant anyway, so a drop there refunds nothing.
    assign w_release    = (r_state == S_GRANT) && !req[r_grant_id] && (r_cnt != BID_W'(1));
    assign w_refund_amt = r_cnt - BID_W'(1);
`else
    assign w_release    = 1'b0;
    assign w_refund_amt = '0;
`endif

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign w_bid[i]     = bid[bid_lsb(i, BID_W) +: BID_W];
            assign w_pending[i] = req[i] && (w_bid[i] != '0);
            assign w_elig[i]    = w_pending[i] && (w_bal[i] >= BAL_W'(w_bid[i]));
            assign w_debit[i]   = (r_state == S_IDLE) && w_any_elig && (w_win == IDX_W'(i));
            assign w_refund[i]  = w_release && (r_grant_id == IDX_W'(i));

            wrr_credit_ctr #(
                .BAL_W       (BAL_W),
                .AMT_W       (BID_W),
                .CREDIT_INIT (CREDIT_INIT)
            ) u_ctr (
                .clk        (clk),
                .rst        (rst),
                .load_init  (w_load),
                .debit      (w_debit[i]),
                .debit_amt  (w_bid[i]),
                .refund     (w_refund[i]),
                .refund_amt (w_refund_amt),
                .balance    (w_bal[i])
            );

            assign balance[bal_lsb(i, BAL_W) +: BAL_W] = w_bal[i];
        end
    endgenerate

    // Scan in round-robin order from rr_ptr; strict '>' keeps the first tied index.
    always_comb begin
        w_any_elig = 1'b0;
        w_win      = '0;
        w_win_bid  = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= C_NCH) w_sum = w_sum - C_NCH;
            w_idx = w_sum[IDX_W-1:0];
            if (w_elig[w_idx] && (w_bid[w_idx] > w_win_bid)) begin
                w_any_elig = 1'b1;
                w_win      = w_idx;
                w_win_bid  = w_bid[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_refill   <= 1'b0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
        end else begin
            r_refill <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_elig) begin
                        r_grant    <= {{(N_CH-1){1'b0}}, 1'b1} << w_win;
                        r_grant_id <= w_win;
                        r_busy     <= 1'b1;
                        r_cnt      <= w_win_bid;
                        r_rr_ptr   <= (w_win == C_LAST) ? '0 : w_win + IDX_W'(1);
                        r_state    <= S_GRANT;
                    end else if (|w_pending) begin
                        r_state <= S_REFILL;
                    end
                end
                S_GRANT: begin
                    r_cnt <= r_cnt - BID_W'(1);
                    if ((r_cnt == BID_W'(1)) || w_release) begin
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_REFILL: begin
                    r_refill <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign refill   = r_refill;

endmodule

`default_nettype wire
